// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small byte FIFO feeding a start / 8 data /
// optional parity / one-or-two stop serializer. tx comes straight from a flop.
module uart_tx_fifo #(
    parameter int clk_freq_hz = 1_000_000,
    parameter int baud_rate   = 115200,
    parameter int fifo_depth  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          fifo_full,
    output logic [$clog2(fifo_depth):0]   fifo_level,
    output logic                          tx_idle,
    output logic                          tx_done,
    output logic                          overflow
);

    localparam int BIT_CLKS = (clk_freq_hz + baud_rate / 2) / baud_rate;
    localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int AW       = $clog2(fifo_depth);
    localparam int LW       = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [fifo_depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;

    // Serializer state
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_bit_q, par_bit_d;
    logic          par_en_q, par_en_d;
    logic          two_stop_q, two_stop_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;

    logic          full_w;
    logic          push;
    logic          drop;
    logic          pop;
    logic          load;
    logic          wrap;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    head;

    assign full_w = (level_q == LW'(fifo_depth));
    assign push   = wr_en && !full_w;
    assign drop   = wr_en && full_w;
    assign head   = mem_q[rd_ptr_q];

    // FIFO pointer, occupancy and sticky-overflow next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
        // A dropped write beats a simultaneous clear.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Serializer next-state; tx_d is the line value for the coming cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        wrap       = (cnt_q == CW'(BIT_CLKS - 1));
        cnt_inc    = wrap ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (level_q != '0) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                cnt_d = cnt_inc;
                if (wrap) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                cnt_d = cnt_inc;
                if (wrap) begin
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                cnt_d = cnt_inc;
                if (wrap) begin
                    state_d = S_STOP;
                    idx_d   = 3'd0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                cnt_d = cnt_inc;
                tx_d  = 1'b1;
                if (wrap) begin
                    if (idx_q == 3'd0 && two_stop_q) begin
                        idx_d = 3'd1;
                    end else begin
                        done_d = 1'b1;
                        if (level_q != '0) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Pop the head and freeze the frame configuration for its duration.
        if (load) begin
            pop        = 1'b1;
            shift_d    = head;
            par_bit_d  = (^head) ^ parity_odd;
            par_en_d   = parity_en;
            two_stop_d = two_stop;
            state_d    = S_START;
            cnt_d      = '0;
            idx_d      = 3'd0;
            tx_d       = 1'b0;
        end
    end

    // FIFO storage write port (no reset needed: contents are gated by level)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // State registers; reset aborts any frame and flushes the FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx         = tx_q;
    assign fifo_full  = full_w;
    assign fifo_level = level_q;
    assign tx_idle    = (level_q == '0) && (state_q == S_IDLE);
    assign tx_done    = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based frame model predicts every output
// each cycle; directed scenarios plus randomized traffic drive it.
module tb_uart_tx_fifo;

    localparam int DEPTH    = 8;
    localparam int BIT_CLKS = (1_000_000 + 115200 / 2) / 115200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       two_stop = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       tx;
    logic       fifo_full;
    logic [3:0] fifo_level;
    logic       tx_idle;
    logic       tx_done;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queued bytes plus the per-cycle line values left in the current frame
    byte unsigned m_fifo[$];
    bit           m_wave[$];
    bit           m_busy;
    bit           m_tx;
    bit           m_done;
    bit           m_ovf;

    uart_tx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .clr_ovf    (clr_ovf),
        .tx         (tx),
        .fifo_full  (fifo_full),
        .fifo_level (fifo_level),
        .tx_idle    (tx_idle),
        .tx_done    (tx_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_fifo.delete();
        m_wave.delete();
        m_busy = 1'b0;
        m_tx   = 1'b1;
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endfunction

    function automatic void build_frame(input byte unsigned d, input bit pe, input bit po, input bit ts);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ po);
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        m_wave.delete();
        foreach (bits[i]) begin
            for (int k = 0; k < BIT_CLKS; k++) m_wave.push_back(bits[i]);
        end
    endfunction

    function automatic void model_tick();
        bit           full_before;
        byte unsigned d;
        full_before = (m_fifo.size() == DEPTH);
        m_done = 1'b0;
        if (m_busy) begin
            if (m_wave.size() != 0) begin
                m_tx = m_wave.pop_front();
            end else begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
        if (!m_busy) begin
            if (m_fifo.size() != 0) begin
                d = m_fifo.pop_front();
                build_frame(d, parity_en, parity_odd, two_stop);
                m_busy = 1'b1;
                m_tx   = m_wave.pop_front();
            end else begin
                m_tx = 1'b1;
            end
        end
        if (wr_en) begin
            if (full_before) m_ovf = 1'b1;
            else m_fifo.push_back(wr_data);
        end
        if (clr_ovf && !(wr_en && full_before)) m_ovf = 1'b0;
    endfunction

    task automatic check_outputs();
        check("tx", tx, m_tx);
        check("level", fifo_level, m_fifo.size());
        check("full", fifo_full, m_fifo.size() == DEPTH);
        check("idle", tx_idle, (m_fifo.size() == 0) && !m_busy);
        check("done", tx_done, m_done);
        check("ovf", overflow, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else model_tick();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        step();
        while (tx_idle !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", n < budget, 1);
        step();
    endtask

    // Write one byte into an idle block; report edges to tx fall, frame length
    // to tx_done, and the line value in the middle of the parity bit slot.
    task automatic send_and_measure(input byte unsigned d, output int lat, output int len, output logic par);
        wr_en = 1'b1;
        wr_data = d;
        step();
        wr_en = 1'b0;
        lat = 0;
        while (tx !== 1'b0 && lat < 50) begin
            step();
            lat++;
        end
        len = 0;
        par = 1'bx;
        while (tx_done !== 1'b1 && len < 500) begin
            step();
            len++;
            if (len == 8 * BIT_CLKS + BIT_CLKS + BIT_CLKS / 2) par = tx;
        end
        step();
    endtask

    initial begin
        int   lat;
        int   len;
        logic par;
        int   n;
        int   d1;
        int   d2;
        int   ndone;
        bit   seen_low;

        // Reset state
        model_reset();
        repeat (3) step();
        check("rst_tx", tx, 1);
        check("rst_level", fifo_level, 0);
        check("rst_idle", tx_idle, 1);
        check("rst_ovf", overflow, 0);
        rst = 1'b1;
        repeat (2) step();

        // 1: 0x55, no parity, one stop
        send_and_measure(8'h55, lat, len, par);
        check("s1_latency", lat, 1);
        check("s1_frame", len, 10 * BIT_CLKS);
        check("s1_idle_after", tx_idle, 1);

        // 2: 0x07 with even, odd parity, then two stop bits
        parity_en = 1'b1;
        parity_odd = 1'b0;
        send_and_measure(8'h07, lat, len, par);
        check("s2_even_frame", len, 11 * BIT_CLKS);
        check("s2_even_bit", par, 1);
        parity_odd = 1'b1;
        send_and_measure(8'h07, lat, len, par);
        check("s2_odd_frame", len, 11 * BIT_CLKS);
        check("s2_odd_bit", par, 0);
        two_stop = 1'b1;
        send_and_measure(8'h07, lat, len, par);
        check("s2_two_stop_frame", len, 12 * BIT_CLKS);
        parity_en = 1'b0;
        parity_odd = 1'b0;
        two_stop = 1'b0;

        // 3: ten back-to-back writes into an idle block
        for (int i = 1; i <= 10; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        check("s3_full", fifo_full, 1);
        check("s3_level", fifo_level, DEPTH);
        check("s3_ovf", overflow, 1);

        // 4: clear overflow, then write while full on the same edge as a pop
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("s4_clr", overflow, 0);
        n = 0;
        while (!(m_busy && m_wave.size() == 0 && m_fifo.size() == DEPTH) && n < 300) begin
            step();
            n++;
        end
        check("s4_found_pop_edge", n < 300, 1);
        wr_en = 1'b1;
        wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        check("s4_drop_ovf", overflow, 1);
        check("s4_level", fifo_level, DEPTH - 1);
        run_until_idle(2000);

        // 5: parity_en changes during the first of two queued frames
        clr_ovf = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h5A;
        step();
        clr_ovf = 1'b0;
        wr_data = 8'hC3;
        step();
        wr_en = 1'b0;
        n = 0;
        ndone = 0;
        d1 = -1;
        d2 = -1;
        while (ndone < 2 && n < 400) begin
            step();
            n++;
            if (n == 20) parity_en = 1'b1;
            if (tx_done === 1'b1) begin
                if (ndone == 0) d1 = n;
                else d2 = n;
                ndone++;
            end
        end
        check("s5_first_done", d1, 10 * BIT_CLKS);
        check("s5_second_done", d2, 21 * BIT_CLKS);
        parity_en = 1'b0;
        run_until_idle(500);

        // 6: asynchronous reset during DATA of 0x3C with three bytes queued
        begin
            byte unsigned seq[4];
            seq[0] = 8'h3C; seq[1] = 8'h11; seq[2] = 8'h22; seq[3] = 8'h33;
            for (int i = 0; i < 4; i++) begin
                wr_en = 1'b1;
                wr_data = seq[i];
                step();
            end
        end
        wr_en = 1'b0;
        repeat (30) step();
        #2 rst = 1'b0;
        #1 model_reset();
        check("s6_tx_now", tx, 1);
        check("s6_level_now", fifo_level, 0);
        check("s6_idle_now", tx_idle, 1);
        step();
        step();
        rst = 1'b1;
        seen_low = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tx !== 1'b1) seen_low = 1'b1;
        end
        check("s6_no_frames", seen_low, 0);

        // 7: randomized traffic, sparse then dense, with config churn
        for (int i = 0; i < 3500; i++) begin
            wr_en   = (i < 2000) ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 20);
            wr_data = 8'($urandom);
            clr_ovf = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 5) parity_en  = 1'($urandom);
            if ($urandom_range(0, 99) < 5) parity_odd = 1'($urandom);
            if ($urandom_range(0, 99) < 5) two_stop   = 1'($urandom);
            step();
        end
        wr_en = 1'b0;
        clr_ovf = 1'b0;
        run_until_idle(3000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
